// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared types for the ALU issue controller.
package alu_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    AND   = 3'd2,
    OR    = 3'd3,
    XOR   = 3'd4,
    SHL   = 3'd5,
    SHR   = 3'd6,
    PASSB = 3'd7
  } opcode_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    opcode_t     opcode;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE_WAIT = 2'd1,
    RESP       = 2'd2
  } issue_state_t;

  // Wide enough for the largest supported ALU latency (15).
  localparam int WAIT_W = 4;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO, registered full/empty, no bypass paths.
module alu_cmd_fifo
  import alu_issue_ctrl_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type elem_t = instruction_t
) (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  push,
  input  logic  pop,
  input  elem_t din,
  output logic  full,
  output logic  empty,
  output elem_t head
);

  localparam int AW = $clog2(DEPTH);

  elem_t        mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra MSB on each pointer separates full (MSBs differ) from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - queues host instructions, issues them to the ALU one at a time, returns results.
// Optional ADD result checker enabled by defining ALU_ISSUE_CHECK_EN.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  instruction_t       cmd_word,
  output instruction_t       iw,
  input  logic [31:0]        alu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_result,
  output opcode_t            rsp_opcode,
  output logic               busy,
`ifdef ALU_ISSUE_CHECK_EN
  output logic               check_error,
  output logic [CNT_W-1:0]   error_count,
`endif
  output logic [CNT_W-1:0]   issued_count
);

  issue_state_t       state;
  issue_state_t       state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               capture;
  instruction_t       fifo_head;

  alu_cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .elem_t (instruction_t)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (cmd_valid),
    .pop     (fifo_pop),
    .din     (cmd_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = ISSUE_WAIT;
        end
      end
      ISSUE_WAIT: begin
        if (wait_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        // Handshake edge can pop the next word directly, avoiding an IDLE bubble.
        if (rsp_ready) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = ISSUE_WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      iw           <= '0;
      wait_cnt     <= '0;
      issued_count <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_opcode   <= opcode_t'('0);
    end else begin
      state <= state_nxt;
      if (fifo_pop) begin
        iw           <= fifo_head;
        wait_cnt     <= WAIT_W'(ALU_LATENCY);
        issued_count <= issued_count + CNT_W'(1);
      end else if (state == ISSUE_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_result;
        rsp_opcode <= iw.opcode;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_CHECK_EN
  logic [31:0] add_sum;

  assign add_sum = iw.a + iw.b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      check_error <= 1'b0;
      error_count <= '0;
    end else if (capture && iw.opcode == ADD && alu_result != add_sum) begin
      check_error <= 1'b1;
      if (error_count != '1) error_count <= error_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed scoreboard bench for alu_issue_ctrl (checker tests under ALU_ISSUE_CHECK_EN).
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  typedef struct {
    logic [31:0] res;
    opcode_t     op;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  instruction_t cmd_word;
  instruction_t iw;
  logic [31:0]  alu_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_result;
  opcode_t      rsp_opcode;
  logic         busy;
  logic [15:0]  issued_count;
`ifdef ALU_ISSUE_CHECK_EN
  logic         check_error;
  logic [15:0]  error_count;
`endif

  int   checks = 0;
  int   errors = 0;
  logic corrupt = 1'b0;
  exp_t sb[$];

  alu_issue_ctrl #(
    .FIFO_DEPTH  (4),
    .ALU_LATENCY (1),
    .CNT_W       (16)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_word     (cmd_word),
    .iw           (iw),
    .alu_result   (alu_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_opcode   (rsp_opcode),
    .busy         (busy),
`ifdef ALU_ISSUE_CHECK_EN
    .check_error  (check_error),
    .error_count  (error_count),
`endif
    .issued_count (issued_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] alu_f(input instruction_t w);
    case (w.opcode)
      ADD:     return w.a + w.b;
      SUB:     return w.a - w.b;
      AND:     return w.a & w.b;
      OR:      return w.a | w.b;
      XOR:     return w.a ^ w.b;
      SHL:     return w.a << w.b[4:0];
      SHR:     return w.a >> w.b[4:0];
      default: return w.b;
    endcase
  endfunction

  function automatic instruction_t mk(input logic [31:0] a, input logic [31:0] b, input opcode_t op);
    instruction_t w;
    w.a = a;
    w.b = b;
    w.opcode = op;
    return w;
  endfunction

  // ALU model: one-cycle registered datapath; corrupt adds 1 to ADD results.
  always @(posedge clock)
    alu_result <= alu_f(iw) + ((corrupt && iw.opcode == ADD) ? 32'd1 : 32'd0);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push(input instruction_t w, output logic acc);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_word  = w;
    acc       = cmd_ready;
    if (acc) begin
      e.res = alu_f(w) + ((corrupt && w.opcode == ADD) ? 32'd1 : 32'd0);
      e.op  = w.opcode;
      sb.push_back(e);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, output int waited);
    exp_t e;
    waited = 0;
    while (!rsp_valid && waited < 50) begin
      step();
      waited++;
    end
    check({tag, "_valid"}, rsp_valid, 1);
    if (rsp_valid) begin
      check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "_result"}, rsp_result, e.res);
        check({tag, "_opcode"}, rsp_opcode, e.op);
      end
    end
    if (rsp_ready) step();
  endtask

  initial begin
    logic         acc;
    int           waited;
    logic         seen;
    instruction_t w3 [3];

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_word  = '0;
    rsp_ready = 1'b1;
    step();
    step();
    check("rst_iw", iw, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_opcode", rsp_opcode, 0);
    check("rst_issued", issued_count, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    step();

    // Single ADD: iw loads one edge after push, response two edges later.
    push(mk(32'd5, 32'd7, ADD), acc);
    check("t1_acc", acc, 1);
    check("t1_iw_not_yet", iw, 0);
    step();
    check("t1_iw", iw, mk(32'd5, 32'd7, ADD));
    check("t1_issued", issued_count, 1);
    expect_rsp("t1", waited);
    check("t1_latency", waited, 2);
    check("t1_rsp_cleared", rsp_valid, 0);
    check("t1_idle", busy, 0);

    // Queue fills: 1 in flight + 4 queued, 6th push rejected.
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(mk(32'(i * 3), 32'(100 + i), (i % 2 == 0) ? ADD : SUB), acc);
      check($sformatf("t2_acc%0d", i), acc, (i < 5) ? 1 : 0);
      if (i == 4) check("t2_full", cmd_ready, 0);
    end
    repeat (5) step();
    check("t2_issued_held", issued_count, 2);
    check("t2_rsp_pending", rsp_valid, 1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) expect_rsp($sformatf("t2_r%0d", i), waited);
    check("t2_issued_end", issued_count, 6);
    check("t2_sb_drained", sb.size(), 0);
    check("t2_idle", busy, 0);

    // Back-to-back issue on handshake edges.
    w3[0] = mk(32'd50, 32'd8, SUB);
    w3[1] = mk(32'hF0F0_0000, 32'h0FF0_1234, XOR);
    w3[2] = mk(32'hFFFF_00FF, 32'h1234_5678, AND);
    for (int i = 0; i < 3; i++) push(w3[i], acc);
    expect_rsp("t3_r0", waited);
    check("t3_iw1", iw, w3[1]);
    check("t3_busy1", busy, 1);
    expect_rsp("t3_r1", waited);
    check("t3_gap1", waited, 2);
    check("t3_iw2", iw, w3[2]);
    expect_rsp("t3_r2", waited);
    check("t3_gap2", waited, 2);

    // Reset during ISSUE_WAIT with two words queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(mk(32'(i), 32'd1, ADD), acc);
    check("t4_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    check("t4_rsp_valid", rsp_valid, 0);
    check("t4_cmd_ready", cmd_ready, 1);
    check("t4_issued", issued_count, 0);
    check("t4_iw", iw, 0);
    check("t4_busy", busy, 0);
    sb.delete();
    step();
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    seen      = 1'b0;
    repeat (10) begin
      step();
      seen |= rsp_valid;
    end
    check("t4_no_rsp", seen, 0);

`ifdef ALU_ISSUE_CHECK_EN
    check("t5_err_init", check_error, 0);
    check("t5_cnt_init", error_count, 0);
    corrupt = 1'b1;
    push(mk(32'd5, 32'd7, ADD), acc);
    expect_rsp("t5_bad", waited);
    corrupt = 1'b0;
    check("t5_err_set", check_error, 1);
    check("t5_cnt_1", error_count, 1);
    push(mk(32'd1, 32'd2, ADD), acc);
    expect_rsp("t5_good", waited);
    check("t5_err_sticky", check_error, 1);
    check("t5_cnt_held", error_count, 1);
`endif

    // 32-bit wrap on ADD.
    push(mk(32'hFFFF_FFFF, 32'd1, ADD), acc);
    expect_rsp("t6", waited);
    check("t6_wrap_result", rsp_result, 0);
`ifdef ALU_ISSUE_CHECK_EN
    check("t6_cnt_unchanged", error_count, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Instruction sequencer that drives the ALU's instruction-word input.
- Accepts instruction words from a host through a valid/ready queue and issues them to the ALU one at a time.
- Waits the ALU's fixed latency, captures the result, and returns it to the host with a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, command queue entries; power of 2, minimum 2.
- ALU_LATENCY, 1, clock edges from the ALU sampling `iw` to `alu_result` being valid; range 1..15.
- CNT_W, 16, width of the statistics counters.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host presents a command word.
- cmd_ready  out  1  queue not full.
- cmd_word  in  instruction_t  command word: a, b, opcode.
- iw  out  instruction_t  instruction word to the ALU `IW` input.
- alu_result  in  32  ALU `result` output.
- rsp_valid  out  1  response holds a captured result.
- rsp_ready  in  1  host accepts the response.
- rsp_result  out  32  captured ALU result.
- rsp_opcode  out  opcode_t  opcode of the instruction that produced rsp_result.
- busy  out  1  high in ISSUE_WAIT or RESP, or when the queue is non-empty.
- issued_count  out  CNT_W  instructions issued since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset values (asynchronous, while reset_n=0):
  - iw = all-zero.
  - rsp_valid = 0; rsp_result = 0; rsp_opcode = all-zero.
  - issued_count = 0.
  - Queue empty, so cmd_ready = 1.
  - State = IDLE.
- Queue push:
  - Push occurs on a rising edge when cmd_valid && cmd_ready.
  - cmd_ready = !full, decoded from registered pointers.
  - When full, cmd_ready is 0 even if a pop happens in the same cycle (no full-bypass).
  - A word pushed into an empty queue becomes poppable on the following edge (no empty-bypass).
- FSM states: IDLE, ISSUE_WAIT, RESP.
- IDLE:
  - If the queue is non-empty at the edge: pop the head into `iw`, load wait counter = ALU_LATENCY, increment issued_count, go to ISSUE_WAIT.
  - Otherwise stay in IDLE.
- ISSUE_WAIT:
  - `iw` is held stable throughout.
  - Counter decrements on each edge.
  - On the edge where the counter is 0: register alu_result into rsp_result and iw.opcode into rsp_opcode, set rsp_valid = 1, go to RESP.
  - Resulting timing: an instruction loaded at edge t is captured at edge t + ALU_LATENCY + 1.
- RESP:
  - rsp_valid, rsp_result and rsp_opcode hold until the handshake rsp_valid && rsp_ready.
  - On the handshake edge rsp_valid clears.
  - If the queue is non-empty on that same edge, the next word is popped into `iw` and the FSM goes directly to ISSUE_WAIT (back-to-back issue, no IDLE bubble).
  - Otherwise go to IDLE.
- `iw` retains the last issued word when idle; it is never cleared except by reset.
- Instruction count vs. queue:
  - At most one instruction is in flight.
  - Up to FIFO_DEPTH further instructions can be queued behind it.
- Queue pointers wrap modulo FIFO_DEPTH using an extra wrap bit to distinguish full from empty.
- Reset mid-operation: the in-flight instruction, queued words and any pending response are discarded; all outputs return to their reset values immediately.
- Width rules: `alu_result` is taken verbatim (32 bits); no arithmetic is performed on data in this block.

Optional Feature:
- Macro: ALU_ISSUE_CHECK_EN.
- Defined:
  - Adds outputs check_error (1 bit, sticky until reset) and error_count (CNT_W bits).
  - At each capture where opcode == ADD, compare alu_result against (iw.a + iw.b) truncated to 32 bits.
  - On mismatch: set check_error and increment error_count; error_count saturates at all-ones.
  - Other opcodes are not checked.
- Undefined: the ports and all associated logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared definitions package (already provides instruction_t and opcode_t) gains:
  - issue_state_t enum: IDLE, ISSUE_WAIT, RESP.
- Sub-module alu_cmd_fifo:
  - Synchronous FIFO parameterised by depth and element type instruction_t.
  - Ports: push, pop, full, empty, head.
- alu_issue_ctrl instantiates alu_cmd_fifo and contains the FSM, wait counter, response register and optional checker.

Test Plan:
- Reset, then push {a=5, b=7, opcode=ADD} with ALU_LATENCY=1 and rsp_ready=1 → `iw` updates one edge after the push; rsp_valid rises 2 edges after `iw` loads; rsp_result = 12, rsp_opcode = ADD; issued_count = 1.
- FIFO_DEPTH=4: push 5 words with rsp_ready=0 → the first issues; the next 4 are accepted; cmd_ready = 0 after the 5th; the 6th push is rejected; issued_count stays 1 until rsp_ready is raised.
- With rsp_ready held 1 and 3 words queued → the three responses return in push order; `iw` reloads on each response handshake edge with no IDLE cycle between them.
- Assert reset_n=0 during ISSUE_WAIT with 2 words queued → rsp_valid = 0, cmd_ready = 1, issued_count = 0 immediately; no response appears after reset is released.
- ALU_ISSUE_CHECK_EN with the bench forcing alu_result = 13 for ADD 5+7 → check_error = 1 and error_count = 1; a following correct ADD leaves check_error = 1 and error_count = 1.
- ADD a=32'hFFFF_FFFF, b=1 → rsp_result = 0; with ALU_ISSUE_CHECK_EN, no error is flagged (truncated compare).
